bidir_port_responder: RTL

//  Far-end responder for a half-duplex bidirectional data port with a read/write control (wr low = host writes, wr high = host reads).

---
 rtl/bidir_pkg.sv | 15 +
 rtl/bidir_fifo.sv | 63 ++++++
 rtl/bidir_port_responder.sv | 105 ++++++++++
 3 files changed

// File: rtl/bidir_pkg.sv
// Shared encodings and default sizing for the bidirectional port responder.
package bidir_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  // Responder phase: who owns the shared line, and the dead cycle between owners.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_TURN  = 2'd2,
    ST_READ  = 2'd3
  } state_e;

endpackage

// File: rtl/bidir_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers. The read word is taken
// straight from the storage array, so there is no output register.
// Pushes while full and pops while empty are ignored here. The caller flags
// those attempts.
module bidir_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   rp_q, rp_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer advance; both pointers wrap modulo 2*DEPTH through the extra bit.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
  end

  // Pointer registers. Reset abandons whatever the array holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage write. A push in a reset cycle is discarded.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) begin
      mem_q[wp_q[AW-1:0]] <= din_i;
    end
  end

  assign level_o = wp_q - rp_q;
  assign full_o  = (level_o == LVL_FULL);
  assign empty_o = (level_o == '0);
  assign dout_o  = empty_o ? '0 : mem_q[rp_q[AW-1:0]];

endmodule

// File: rtl/bidir_port_responder.sv
// Far-end responder for a half-duplex shared data line.
// Protocol: wr=0 means the host drives data and each stb cycle in WRITE
// pushes one word. wr=1 means the responder drives data and each stb cycle
// in READ pops one word. A transfer is accepted on the rising edge where it
// is qualified, and ack reports it for the following cycle. There is no
// back-pressure: the host learns of a drop only through ack=0 and ovf/udf.
module bidir_port_responder
  import bidir_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          stb,
  inout  wire  [DW-1:0] data,
  output logic          ack,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf,
  output logic [1:0]    dbg_state_o,
  output logic          dbg_drive_o
);

  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_xfer;
  logic          rd_xfer;
  logic          push;
  logic          pop;
  logic          drive_en;
  logic [DW-1:0] out_word;

  bidir_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (data),
    .dout_o  (out_word),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Next phase. A direction change from WRITE always passes through TURN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = wr ? ST_TURN : ST_WRITE;
      ST_WRITE: state_d = wr ? ST_TURN : ST_WRITE;
      ST_TURN:  state_d = wr ? ST_READ : ST_WRITE;
      ST_READ:  state_d = wr ? ST_READ : ST_WRITE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Transfer qualification and status flags. stb outside WRITE/READ is ignored.
  always_comb begin
    wr_xfer = (state_q == ST_WRITE) & ~wr & stb;
    rd_xfer = (state_q == ST_READ) & wr & stb;
    push    = wr_xfer & ~full;
    pop     = rd_xfer & ~empty;
    ack_d   = push | pop;
    ovf_d   = ovf_q | (wr_xfer & full);
    udf_d   = udf_q | (rd_xfer & empty);
  end

  // Phase, ack and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // wr and rst gate the drive directly, so the line is released in the same
  // cycle the host takes it back or reset arrives.
  assign drive_en = (state_q == ST_READ) & wr & ~rst;
  assign data     = drive_en ? out_word : {DW{1'bz}};

  assign ack         = ack_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;
  assign dbg_state_o = state_q;
  assign dbg_drive_o = drive_en;

endmodule
